// File: rtl/stage_mem_unit.sv
// rtl/stage_mem_unit.sv - M-stage memory unit with posted store buffer, load forwarding and halt drain
//
// Optional feature: define STAGE_MEM_LLSC_EN to compile in LL/SC support (link register).
//
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_memRead/in_memWrite/in_datomic/in_halt, in_addr, in_store
//                             M-stage operation, held by upstream while stall_out=1
//   stall_out                 freeze upstream and hold M-stage inputs
//   out_valid/out_load        load data (or SC success flag)
//   halt_out                  sticky halt, set once all posted stores have drained
//   dmem_ren/dmem_wen/dmem_addr/dmem_store/dmem_load/dhit   dcache port
//   snoop_valid/snoop_addr    coherence invalidate (clears a matching link)
module stage_mem_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STB_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic              in_memRead,
    input  logic              in_memWrite,
    input  logic              in_datomic,
    input  logic              in_halt,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_store,
    output logic              stall_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_load,
    output logic              halt_out,
    output logic              dmem_ren,
    output logic              dmem_wen,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_store,
    input  logic [DATA_W-1:0] dmem_load,
    input  logic              dhit,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr
);
    localparam int PW = $clog2(STB_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] stb_addr_q [STB_DEPTH];
    logic [DATA_W-1:0] stb_data_q [STB_DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0]     count_q, count_d;

    logic              atomic, active, is_load, is_store, is_halt;
    logic              full, empty, enq, deq, fwd_hit, load_miss;
    logic [DATA_W-1:0] fwd_data;
    logic              stall_c, valid_c;
    logic [DATA_W-1:0] load_c;
    logic              ren_c, wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] store_c;

`ifdef STAGE_MEM_LLSC_EN
    logic              link_valid_q, link_valid_d;
    logic [WW-1:0]     link_addr_q, link_addr_d;
    logic              is_sc, sc_ok;
    assign atomic = in_datomic;
    assign is_sc  = active & in_valid & in_memWrite & in_datomic;
    assign sc_ok  = link_valid_q && (link_addr_q == in_addr[ADDR_W-1:2]);
`else
    logic              unused_llsc;
    assign atomic      = 1'b0;
    assign unused_llsc = ^{in_datomic, snoop_valid, snoop_addr};
`endif

    // Once halted the unit ignores every operation.
    assign active   = (state_q != HALTED);
    assign is_load  = active & in_valid & in_memRead;
    assign is_store = active & in_valid & in_memWrite & ~atomic;
    assign is_halt  = active & in_valid & in_halt;
    assign full     = (count_q == CW'(STB_DEPTH));
    assign empty    = (count_q == '0);
    assign deq      = (state_q == DRAIN) && dhit;
    assign load_miss = is_load && !fwd_hit;

    // Walk entries oldest to youngest so the last match wins. The head entry is
    // skipped in the cycle its write completes: memory already holds that data.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < STB_DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (i != 0 || !deq) &&
                (stb_addr_q[idx][ADDR_W-1:2] == in_addr[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = stb_data_q[idx];
            end
        end
    end

    // Per-operation handshake: stall, result and enqueue.
    always_comb begin
        stall_c = 1'b0;
        valid_c = 1'b0;
        load_c  = '0;
        enq     = 1'b0;
        if (is_halt) begin
            stall_c = !((state_q == IDLE) && empty);
        end else if (is_load) begin
            if (fwd_hit) begin
                valid_c = 1'b1;
                load_c  = fwd_data;
            end else if ((state_q == LOAD) && dhit) begin
                valid_c = 1'b1;
                load_c  = dmem_load;
            end else begin
                stall_c = 1'b1;
            end
        end else if (is_store) begin
            // A full buffer still accepts when the head retires this cycle.
            if (full && !deq) stall_c = 1'b1;
            else              enq     = 1'b1;
        end
`ifdef STAGE_MEM_LLSC_EN
        else if (is_sc) begin
            // SC resolves only against a drained buffer so it is ordered after older stores.
            if ((state_q == IDLE) && empty) begin
                valid_c = 1'b1;
                load_c  = DATA_W'(sc_ok);
                enq     = sc_ok;
            end else begin
                stall_c = 1'b1;
            end
        end
`endif
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_halt && empty)  state_d = HALTED;
                else if (load_miss)    state_d = LOAD;
                else if (!empty)       state_d = DRAIN;
            end
            LOAD:    if (dhit) state_d = IDLE;
            DRAIN:   if (dhit) state_d = IDLE;
            default: state_d = HALTED;
        endcase
    end

    // FSM: dcache port outputs
    always_comb begin
        ren_c   = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        store_c = '0;
        case (state_q)
            LOAD: begin
                ren_c  = 1'b1;
                addr_c = in_addr;
            end
            DRAIN: begin
                wen_c   = 1'b1;
                addr_c  = stb_addr_q[head_q];
                store_c = stb_data_q[head_q];
            end
            default: ;
        endcase
    end

    assign head_d  = deq ? head_q + 1'b1 : head_q;
    assign tail_d  = enq ? tail_q + 1'b1 : tail_q;
    assign count_d = count_q + CW'(enq) - CW'(deq);

    // FSM: state and buffer bookkeeping registers
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: count_q alone says which entries are live.
    always_ff @(posedge CLK) begin
        if (enq) begin
            stb_addr_q[tail_q] <= in_addr;
            stb_data_q[tail_q] <= in_store;
        end
    end

`ifdef STAGE_MEM_LLSC_EN
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (snoop_valid && (snoop_addr[ADDR_W-1:2] == link_addr_q)) link_valid_d = 1'b0;
        if (is_halt || (is_sc && !stall_c))                         link_valid_d = 1'b0;
        if (is_load && atomic && valid_c) begin
            link_valid_d = 1'b1;
            link_addr_d  = in_addr[ADDR_W-1:2];
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end
`endif

    // Reset forces every output low immediately, independent of the held inputs.
    assign stall_out  = !nRST && stall_c;
    assign out_valid  = !nRST && valid_c;
    assign out_load   = nRST ? '0 : load_c;
    assign halt_out   = !nRST && (state_q == HALTED);
    assign dmem_ren   = !nRST && ren_c;
    assign dmem_wen   = !nRST && wen_c;
    assign dmem_addr  = nRST ? '0 : addr_c;
    assign dmem_store = nRST ? '0 : store_c;

endmodule

// File: tb/tb_stage_mem_unit.sv
// tb/tb_stage_mem_unit.sv - directed self-checking bench for stage_mem_unit
module tb_stage_mem_unit;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid, in_memRead, in_memWrite, in_datomic, in_halt;
    logic [31:0] in_addr, in_store;
    logic        stall_out, out_valid, halt_out;
    logic [31:0] out_load;
    logic        dmem_ren, dmem_wen;
    logic [31:0] dmem_addr, dmem_store, dmem_load;
    logic        dhit, snoop_valid;
    logic [31:0] snoop_addr;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] wa [8];
    logic [31:0] wd [8];
    int          nw;
    logic        got_halt;

    stage_mem_unit dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_memRead(in_memRead), .in_memWrite(in_memWrite),
        .in_datomic(in_datomic), .in_halt(in_halt),
        .in_addr(in_addr), .in_store(in_store),
        .stall_out(stall_out), .out_valid(out_valid), .out_load(out_load), .halt_out(halt_out),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_store(dmem_store),
        .dmem_load(dmem_load), .dhit(dhit),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic op(input logic rd, input logic wr, input logic at, input logic hl,
                      input logic [31:0] a, input logic [31:0] d);
        in_valid    = rd | wr | hl;
        in_memRead  = rd;
        in_memWrite = wr;
        in_datomic  = at;
        in_halt     = hl;
        in_addr     = a;
        in_store    = d;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Hold dhit high for n cycles with no new ops; log every dcache write.
    task automatic run_dhit(input int n);
        nw   = 0;
        dhit = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            if (dmem_wen && nw < 8) begin
                wa[nw] = dmem_addr;
                wd[nw] = dmem_store;
                nw++;
            end
            tick();
        end
        dhit = 1'b0;
    endtask

    initial begin
        nRST = 1'b1; dhit = 1'b0; dmem_load = 32'h0; snoop_valid = 1'b0; snoop_addr = 32'h0;
        idle();
        #1;
        chk1("rst_stall", stall_out, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_halt", halt_out, 1'b0);
        chk1("rst_ren", dmem_ren, 1'b0);
        chk1("rst_wen", dmem_wen, 1'b0);
        chk32("rst_addr", dmem_addr, 32'h0);
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
        #1;
        chk1("rst_load_nostall", stall_out, 1'b0);
        idle();
        tick();
        nRST = 1'b0;

        // Fill the buffer with dhit low, then overflow by one
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            #1;
            chk1("fill_nostall", stall_out, 1'b0);
            if (i == 2) begin
                chk1("fill_drain_wen", dmem_wen, 1'b1);
                chk32("fill_drain_addr", dmem_addr, 32'h100);
            end
            tick();
        end
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h110, 32'hA4);
        #1;
        chk1("full_stall0", stall_out, 1'b1);
        tick();
        chk1("full_stall1", stall_out, 1'b1);
        dhit = 1'b1;
        #1;
        chk1("full_dhit_accept", stall_out, 1'b0);
        chk32("full_dhit_addr", dmem_addr, 32'h100);
        chk32("full_dhit_data", dmem_store, 32'hA0);
        tick();
        idle();
        dhit = 1'b0;
        run_dhit(12);
        chk32("wrap_writes", 32'(nw), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk32("wrap_addr", wa[i], 32'h104 + 32'(4 * i));
            chk32("wrap_data", wd[i], 32'hA1 + 32'(i));
        end

        // Youngest-entry forwarding
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hDEAD);
        tick();
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hBEEF);
        tick();
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0);
        #1;
        chk1("fwd_valid", out_valid, 1'b1);
        chk32("fwd_data", out_load, 32'hBEEF);
        chk1("fwd_nostall", stall_out, 1'b0);
        chk1("fwd_noren", dmem_ren, 1'b0);
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h202, 32'h0);
        #1;
        chk32("fwd_subword", out_load, 32'hBEEF);
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0);
        #1;
        chk1("miss_in_drain_stall", stall_out, 1'b1);
        chk1("miss_in_drain_valid", out_valid, 1'b0);
        chk1("miss_in_drain_wen", dmem_wen, 1'b1);
        chk1("miss_in_drain_ren", dmem_ren, 1'b0);
        idle();
        run_dhit(8);
        chk32("fwd_drain_n", 32'(nw), 32'd2);
        chk32("fwd_drain_d0", wd[0], 32'hDEAD);
        chk32("fwd_drain_d1", wd[1], 32'hBEEF);

        // Head entry being retired is not forwarded
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h55);
        tick();
        idle();
        tick();
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
        #1;
        chk1("head_fwd_valid", out_valid, 1'b1);
        chk32("head_fwd_data", out_load, 32'h55);
        dhit = 1'b1;
        #1;
        chk1("head_deq_stall", stall_out, 1'b1);
        chk1("head_deq_valid", out_valid, 1'b0);
        tick();
        dmem_load = 32'h55;
        #1;
        chk1("head_miss_stall", stall_out, 1'b1);
        tick();
        chk1("head_load_ren", dmem_ren, 1'b1);
        chk32("head_load_addr", dmem_addr, 32'h500);
        chk1("head_load_valid", out_valid, 1'b1);
        chk32("head_load_data", out_load, 32'h55);
        tick();
        idle();
        dhit = 1'b0;

        // Load miss on empty buffer, dhit on fourth cycle
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
        #1;
        chk1("miss_c0_stall", stall_out, 1'b1);
        chk1("miss_c0_ren", dmem_ren, 1'b0);
        tick();
        chk1("miss_c1_stall", stall_out, 1'b1);
        chk1("miss_c1_ren", dmem_ren, 1'b1);
        chk32("miss_c1_addr", dmem_addr, 32'h300);
        tick();
        chk1("miss_c2_stall", stall_out, 1'b1);
        chk1("miss_c2_valid", out_valid, 1'b0);
        tick();
        dhit = 1'b1;
        dmem_load = 32'h1234;
        #1;
        chk1("miss_c3_stall", stall_out, 1'b0);
        chk1("miss_c3_valid", out_valid, 1'b1);
        chk32("miss_c3_data", out_load, 32'h1234);
        tick();
        idle();
        dhit = 1'b0;
        #1;
        chk1("miss_done_ren", dmem_ren, 1'b0);

        // Reset mid-DRAIN discards buffered stores
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h88);
        tick();
        idle();
        tick();
        nRST = 1'b1;
        #1;
        chk1("rst_drain_wen", dmem_wen, 1'b0);
        tick();
        nRST = 1'b0;
        run_dhit(6);
        chk32("rst_drain_discard", 32'(nw), 32'd0);

`ifdef STAGE_MEM_LLSC_EN
        // LL / snoop / SC fails; LL / SC succeeds
        dmem_load = 32'h99;
        dhit = 1'b1;
        op(1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
        tick();
        chk32("ll_data", out_load, 32'h99);
        tick();
        idle();
        snoop_valid = 1'b1;
        snoop_addr  = 32'h400;
        tick();
        snoop_valid = 1'b0;
        op(1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h77);
        #1;
        chk1("sc_fail_valid", out_valid, 1'b1);
        chk32("sc_fail_result", out_load, 32'h0);
        tick();
        idle();
        run_dhit(6);
        chk32("sc_fail_nostore", 32'(nw), 32'd0);
        dhit = 1'b1;
        op(1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
        tick();
        tick();
        op(1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h77);
        #1;
        chk32("sc_ok_result", out_load, 32'h1);
        tick();
        idle();
        run_dhit(6);
        chk32("sc_ok_n", 32'(nw), 32'd1);
        chk32("sc_ok_addr", wa[0], 32'h400);
        chk32("sc_ok_data", wd[0], 32'h77);
`endif

        // Halt waits for the buffer to drain, then sticks until reset
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h11);
        tick();
        op(1'b0, 1'b1, 1'b0, 1'b0, 32'h604, 32'h22);
        tick();
        op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        chk1("halt_stall", stall_out, 1'b1);
        chk1("halt_pending", halt_out, 1'b0);
        got_halt = 1'b0;
        nw = 0;
        dhit = 1'b1;
        for (int i = 0; i < 20 && !got_halt; i++) begin
            #1;
            if (halt_out) got_halt = 1'b1;
            else begin
                if (dmem_wen) nw++;
                tick();
            end
        end
        dhit = 1'b0;
        chk1("halt_reached", got_halt, 1'b1);
        chk32("halt_after_drains", 32'(nw), 32'd2);
        op(1'b1, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0);
        #1;
        chk1("halted_noren", dmem_ren, 1'b0);
        chk1("halted_nowen", dmem_wen, 1'b0);
        tick();
        idle();
        tick();
        chk1("halt_sticky", halt_out, 1'b1);
        nRST = 1'b1;
        #1;
        chk1("halt_reset_clear", halt_out, 1'b0);
        tick();
        nRST = 1'b0;
        #1;
        chk1("post_reset_halt", halt_out, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stage_mem_unit.md
STAGE_MEM_UNIT -- requirements
Module: stage_mem_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width; word compare uses bits [ADDR_W-1:2].
REQ-003 SHALL have parameter STB_DEPTH, default 4, store-buffer entries, power of 2, >=2.
REQ-004 CLK  in  1  clock, rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-high (1 = reset).
REQ-006 in_valid, in_memRead, in_memWrite, in_datomic, in_halt  in  1 each  M-stage op qualifiers.
REQ-007 in_addr  in  ADDR_W  access address; in_store  in  DATA_W  store data.
REQ-008 stall_out  out  1  freeze upstream latches and hold M-stage inputs.
REQ-009 out_valid  out  1  out_load valid; out_load  out  DATA_W  load or SC result.
REQ-010 halt_out  out  1  sticky halt after drain.
REQ-011 dmem_ren, dmem_wen  out  1; dmem_addr  out  ADDR_W; dmem_store  out  DATA_W; dmem_load  in  DATA_W; dhit  in  1  dcache port.
REQ-012 snoop_valid  in  1; snoop_addr  in  ADDR_W  coherence invalidate.

Function
REQ-013 SHALL hold posted stores in a FIFO of STB_DEPTH entries {addr,data}; occupancy count is clog2(STB_DEPTH)+1 bits; pointers wrap modulo STB_DEPTH.
REQ-014 SHALL run FSM IDLE, LOAD, DRAIN, HALTED; dmem_ren=1 only in LOAD, dmem_wen=1 only in DRAIN, never both.
REQ-015 Store (in_valid&in_memWrite&!in_datomic) SHALL enqueue on the edge when not full, with stall_out=0; when full SHALL stall_out=1, except full with DRAIN&dhit same cycle accepts the enqueue (count unchanged).
REQ-016 Load SHALL compare word address against all valid entries; on match forward youngest entry data with out_valid=1 same cycle, stall_out=0, no dcache access.
REQ-017 Load with no match SHALL stall_out=1, enter LOAD from IDLE (or after current DRAIN completes), drive dmem_addr=in_addr, and on dhit set out_valid=1, out_load=dmem_load, stall_out=0, return to IDLE.
REQ-018 IDLE->DRAIN when buffer non-empty and no unmatched load pending; DRAIN presents head entry; on dhit dequeues, ->IDLE.
REQ-019 An in-flight DRAIN SHALL never be abandoned; a load arriving mid-DRAIN waits for dhit.
REQ-020 Halt (in_valid&in_halt) SHALL stall_out=1 until buffer empty and FSM IDLE, then ->HALTED, halt_out=1 until reset; HALTED issues no dcache requests.
REQ-021 out_valid SHALL be 0 for non-load ops and while stall_out=1.
REQ-022 Simultaneous enqueue and dequeue when not full SHALL leave count unchanged; forwarding ignores the entry dequeuing that cycle only if its dhit has occurred.

Reset
REQ-023 nRST=1 SHALL immediately force state IDLE, count 0, pointers 0, link invalid, and all outputs 0.
REQ-024 Reset mid-LOAD or mid-DRAIN SHALL discard the request and all buffered stores.

Configuration
REQ-025 Macro STAGE_MEM_LLSC_EN SHALL compile in LL/SC support: link register {valid,addr}.
REQ-026 With STAGE_MEM_LLSC_EN: LL (memRead&datomic) performs a normal load and sets link; SC (memWrite&datomic) stalls until buffer drained, then if link valid and word address equal enqueues the store and returns out_load=1, else returns 0 without storing; link clears on any SC, on snoop_valid with matching word address, and on halt.
REQ-027 Without STAGE_MEM_LLSC_EN: in_datomic ignored (LL=load, SC=store), snoop inputs unused, no link register.

Verification
REQ-028 Four stores to 0x100,0x104,0x108,0x10C with dhit=0 -> no stall; fifth store -> stall_out=1 until first dhit in DRAIN.
REQ-029 Store 0xDEAD to 0x200 then 0xBEEF to 0x200, then load 0x200 -> out_valid=1 same cycle, out_load=0xBEEF, dmem_ren=0.
REQ-030 Load 0x300 empty buffer, dhit after 3 cycles with dmem_load=0x1234 -> stall_out=1 for 3 cycles, then out_load=0x1234.
REQ-031 Two buffered stores then halt -> halt_out=0 until second dequeue dhit, then halt_out=1 sticky; nRST=1 clears it.
REQ-032 (LLSC_EN) LL 0x400, snoop 0x400, SC 0x400 -> out_load=0, no enqueue; repeat without snoop -> out_load=1, store drained to 0x400.
